uart_tx_ctrl: RTL
=================

// Module: uart_tx_ctrl
// PURPOSE
//   Frame-sequencing FSM for the UART transmitter. Accepts a byte request, pulses LOAD so the
//   serializer and parity calculator capture P_DATA, then steps the output mux through
//   start / data / parity / stop bits on baud ticks. Sits between the bus-side Tx register
//   and the serializer, parity calculator and output mux.
// PARAMETERS
//   DATA_BITS  8  data bits per frame; legal range 5..8
// PORTS
//   CLK         in   1  system clock; all state updates on posedge
//   RST         in   1  asynchronous, active-high reset
//   DATA_VALID  in   1  byte request from the Tx register (level; sampled when accepted)
//   PAR_EN      in   1  parity bit enable; latched at accept
//   STOP2       in   1  1 = two stop bits, 0 = one; latched at accept
//   BAUD_TICK   in   1  one-CLK pulse per bit period from the baud generator
//   LOAD        out  1  one-cycle pulse at accept; serializer/parity capture P_DATA
//   BAUD_CLR    out  1  one-cycle pulse at accept, coincident with LOAD; restarts the baud divider
//   SER_EN      out  1  serializer shift enable; high only on BAUD_TICK cycles in DATA
//   BIT_IDX     out  3  index of the data bit on the line; 0 = LSB
//   MUX_SEL     out  2  00 start(0), 01 data, 10 parity, 11 stop/idle(1)
//   BUSY        out  1  high from the accept cycle until the frame completes
//   DONE        out  1  one-cycle pulse on the final stop-bit tick
// BEHAVIOUR
//   - Reset: state IDLE; LOAD=BAUD_CLR=SER_EN=BUSY=DONE=0; BIT_IDX=0; MUX_SEL=11 (line high).
//     Reset asserted mid-frame aborts immediately. No partial frame resumes after release.
//   - States: IDLE, START, DATA, PARITY, STOP. All registered; outputs are decoded from the state.
//   - IDLE: on DATA_VALID=1, accept. LOAD and BAUD_CLR pulse for 1 cycle, PAR_EN/STOP2 latch,
//     and the next state is START. The accept cycle itself already has BUSY=1.
//   - START: MUX_SEL=00. On BAUD_TICK go to DATA with BIT_IDX=0.
//   - DATA: MUX_SEL=01. On each BAUD_TICK, SER_EN=1 and BIT_IDX increments.
//     On the tick with BIT_IDX==DATA_BITS-1, BIT_IDX returns to 0 and the next state is
//     PARITY if the latched PAR_EN=1, else STOP.
//   - PARITY: MUX_SEL=10. On BAUD_TICK go to STOP.
//   - STOP: MUX_SEL=11. If the latched STOP2=1, the first tick only sets the stop_cnt flag.
//     The final tick pulses DONE and ends the frame:
//       - If DATA_VALID=1 on that cycle, it is also an accept cycle (LOAD, BAUD_CLR, latch,
//         next state START, BUSY stays 1). Back-to-back frames have no idle gap.
//       - Otherwise the next state is IDLE and BUSY=0 from the next cycle.
//   - DATA_VALID while BUSY, outside the final-stop-tick accept, is ignored (no LOAD).
//   - BAUD_TICK in IDLE has no effect. A BAUD_TICK coincident with the accept cycle is
//     ignored, because BAUD_CLR realigns the divider.
//   - Frame length in ticks: 1 + DATA_BITS + PAR_EN + (1+STOP2).
//     Config changes mid-frame have no effect until the next accept.
//   - Latency: DATA_VALID high in IDLE -> LOAD in the same cycle -> MUX_SEL=00 on the next cycle.
// STRUCTURE
//   - Shared package uart_pkg: state encoding localparams (IDLE..STOP) and MUX_SEL codes
//     (MUX_START=2'b00, MUX_DATA=2'b01, MUX_PAR=2'b10, MUX_STOP=2'b11).
//     The serializer and output mux use the same codes.
//   - One sub-module: uart_tx_bit_counter. It is a 3-bit counter with clear/inc/terminal-count
//     for DATA_BITS, using the same CLK/RST.
//   - The FSM and stop-bit flag stay in this module.
// TESTING
//   1. DATA_BITS=8, PAR_EN=0, STOP2=0, single DATA_VALID pulse
//      -> LOAD/BAUD_CLR once; MUX_SEL 00, then 01 for 8 ticks, then 11 for 1 tick.
//      -> SER_EN on exactly 8 cycles, BIT_IDX 0..7; DONE after tick 10; BUSY high 10 tick periods.
//   2. PAR_EN=1, STOP2=1 -> MUX_SEL=10 for tick 10, 11 for ticks 11-12; DONE only on tick 12.
//   3. DATA_VALID held high continuously -> LOAD on the final-stop-tick cycle.
//      -> MUX_SEL goes 11 -> 00 with no IDLE cycle; BUSY never drops; DONE and LOAD coincide.
//   4. DATA_VALID pulsed during DATA, and PAR_EN toggled mid-frame
//      -> no extra LOAD; frame ends per the config latched at accept.
//   5. RST asserted during the data bit at BIT_IDX=4 -> outputs reach reset values asynchronously.
//      -> After release, a new DATA_VALID runs a complete frame from START.
//   6. BAUD_TICK in the accept cycle and in IDLE -> ignored; the START bit still lasts one full tick period.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmit state encoding and output-mux select codes
package uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;
  localparam int CNT_W = 3;
  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_DATA  = 2'b01;
  localparam logic [1:0] MUX_PAR   = 2'b10;
  localparam logic [1:0] MUX_STOP  = 2'b11;
endpackage

// File: rtl/uart_tx_bit_counter.sv
// uart_tx_bit_counter: data-bit index counter that wraps to zero after the last data bit
module uart_tx_bit_counter
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    tc    = cnt_q == CNT_W'(DATA_BITS - 1);
    cnt_d = clr ? '0 : inc ? (tc ? '0 : cnt_q + 1'b1) : cnt_q;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer driving load, shift enable and output-mux select
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DATA_VALID,
  input  logic             PAR_EN,
  input  logic             STOP2,
  input  logic             BAUD_TICK,
  output logic             LOAD,
  output logic             BAUD_CLR,
  output logic             SER_EN,
  output logic [CNT_W-1:0] BIT_IDX,
  output logic [1:0]       MUX_SEL,
  output logic             BUSY,
  output logic             DONE
);
  state_e state_q, state_d;
  logic par_en_q, par_en_d, stop2_q, stop2_d, stop_cnt_q, stop_cnt_d;
  logic data_tick, last_stop, accept, tc;
  uart_tx_bit_counter #(.DATA_BITS(DATA_BITS)) u_cnt (
    .CLK(CLK),
    .RST(RST),
    .clr(accept),
    .inc(data_tick),
    .cnt(BIT_IDX),
    .tc (tc)
  );
  // A final stop tick may also accept the next byte, so frames chain without an idle cycle
  always_comb begin
    data_tick  = state_q == ST_DATA && BAUD_TICK;
    last_stop  = state_q == ST_STOP && BAUD_TICK && (!stop2_q || stop_cnt_q);
    accept     = !RST && DATA_VALID && (state_q == ST_IDLE || last_stop);
    par_en_d   = accept ? PAR_EN : par_en_q;
    stop2_d    = accept ? STOP2 : stop2_q;
    stop_cnt_d = state_q == ST_STOP && (stop_cnt_q || BAUD_TICK) && !last_stop;
    state_d    = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_IDLE;
      ST_START:  state_d = BAUD_TICK ? ST_DATA : ST_START;
      ST_DATA:   state_d = (BAUD_TICK && tc) ? (par_en_q ? ST_PARITY : ST_STOP) : ST_DATA;
      ST_PARITY: state_d = BAUD_TICK ? ST_STOP : ST_PARITY;
      ST_STOP:   state_d = last_stop ? ST_IDLE : ST_STOP;
      default:   state_d = ST_IDLE;
    endcase
    if (accept) state_d = ST_START;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q    <= ST_IDLE;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
    end
  assign LOAD     = accept;
  assign BAUD_CLR = accept;
  assign SER_EN   = data_tick;
  assign DONE     = last_stop;
  assign BUSY     = state_q != ST_IDLE || accept;
  assign MUX_SEL  = state_q == ST_START  ? MUX_START :
                    state_q == ST_DATA   ? MUX_DATA  :
                    state_q == ST_PARITY ? MUX_PAR   : MUX_STOP;
endmodule
